// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: START / STOP / byte write with ACK sample / byte read with ACK-NACK.
// Each bus slot is four quarter-phases of DIV clk cycles; all bus outputs are registered.
module i2c_byte_master #(
    parameter int unsigned DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       send,
    input  logic [7:0] datasend,
    input  logic       receive,
    input  logic       last,
    input  logic       stop,
    input  logic       sda_i,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       sended,
    output logic       received,
    output logic [7:0] datareceive,
    output logic       ack_err
);

    localparam int unsigned CW = 16;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PULSE = CW'(DIV - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_HOLD, S_START, S_WBIT, S_WACK, S_RBIT, S_RACK, S_STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    phase_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          last_q;
    logic          sample_q;
    logic          scl_q;
    logic          sda_oe_q;
    logic          busy_q;
    logic          sended_q;
    logic          received_q;
    logic [7:0]    data_q;
    logic          ack_err_q;

    logic phase_end;
    logic sample_now;
    logic pulse_now;

    assign phase_end  = (cnt_q == CNT_LAST);
    assign sample_now = (phase_q == 2'd2) && (cnt_q == '0);
    // Completion pulse lands on the final cycle of the last slot, i.e. the last busy cycle.
    assign pulse_now  = (phase_q == 2'd3) && (cnt_q == CNT_PULSE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            phase_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            last_q     <= 1'b0;
            sample_q   <= 1'b0;
            scl_q      <= 1'b1;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            sended_q   <= 1'b0;
            received_q <= 1'b0;
            data_q     <= '0;
            ack_err_q  <= 1'b0;
        end else begin
            sended_q   <= 1'b0;
            received_q <= 1'b0;
            if (!busy_q) begin
                cnt_q   <= '0;
                phase_q <= '0;
                if (start) begin
                    state_q  <= S_START;
                    busy_q   <= 1'b1;
                    sda_oe_q <= 1'b0;
                end else if (state_q == S_HOLD) begin
                    if (stop) begin
                        state_q  <= S_STOP;
                        busy_q   <= 1'b1;
                        sda_oe_q <= 1'b1;
                    end else if (send) begin
                        state_q  <= S_WBIT;
                        busy_q   <= 1'b1;
                        shift_q  <= datasend;
                        bit_q    <= 3'd7;
                        sda_oe_q <= ~datasend[7];
                    end else if (receive) begin
                        state_q  <= S_RBIT;
                        busy_q   <= 1'b1;
                        bit_q    <= 3'd7;
                        last_q   <= last;
                        sda_oe_q <= 1'b0;
                    end
                end
            end else begin
                cnt_q <= phase_end ? '0 : cnt_q + CW'(1);
                if (phase_end) phase_q <= phase_q + 2'd1;

                if (sample_now) begin
                    if (state_q == S_RBIT) shift_q  <= {shift_q[6:0], sda_i};
                    if (state_q == S_WACK) sample_q <= sda_i;
                end

                if (pulse_now && state_q == S_WACK) begin
                    sended_q  <= 1'b1;
                    ack_err_q <= sample_q;
                end
                if (pulse_now && state_q == S_RACK) begin
                    received_q <= 1'b1;
                    data_q     <= shift_q;
                end

                if (phase_end) begin
                    case (phase_q)
                        2'd0: scl_q <= 1'b1;
                        2'd1: begin
                            if (state_q == S_START)     sda_oe_q <= 1'b1;
                            else if (state_q == S_STOP) sda_oe_q <= 1'b0;
                        end
                        2'd2: if (state_q != S_STOP) scl_q <= 1'b0;
                        2'd3: begin
                            // Slot boundary: SCL is low, so SDA may change for the next slot.
                            case (state_q)
                                S_START: begin
                                    state_q <= S_HOLD;
                                    busy_q  <= 1'b0;
                                end
                                S_STOP: begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                end
                                S_WBIT: begin
                                    if (bit_q == 3'd0) begin
                                        state_q  <= S_WACK;
                                        sda_oe_q <= 1'b0;
                                    end else begin
                                        bit_q    <= bit_q - 3'd1;
                                        shift_q  <= {shift_q[6:0], 1'b0};
                                        sda_oe_q <= ~shift_q[6];
                                    end
                                end
                                S_RBIT: begin
                                    if (bit_q == 3'd0) begin
                                        state_q  <= S_RACK;
                                        sda_oe_q <= ~last_q;
                                    end else begin
                                        bit_q <= bit_q - 3'd1;
                                    end
                                end
                                S_WACK: begin
                                    state_q <= S_HOLD;
                                    busy_q  <= 1'b0;
                                end
                                S_RACK: begin
                                    state_q  <= S_HOLD;
                                    busy_q   <= 1'b0;
                                    sda_oe_q <= 1'b0;
                                end
                                default: begin
                                    state_q <= S_IDLE;
                                    busy_q  <= 1'b0;
                                end
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign scl         = scl_q;
    assign sda_oe      = sda_oe_q;
    assign busy        = busy_q;
    assign sended      = sended_q;
    assign received    = received_q;
    assign datareceive = data_q;
    assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with DIV=4 and an open-drain slave model on SDA.
module tb_i2c_byte_master;

    localparam int unsigned DIV  = 4;
    localparam int          SLOT = 4 * DIV;
    localparam int          NTR  = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       send = 1'b0;
    logic [7:0] datasend = 8'h00;
    logic       receive = 1'b0;
    logic       last = 1'b0;
    logic       stop = 1'b0;
    logic       sda_i;
    logic       scl;
    logic       sda_oe;
    logic       busy;
    logic       sended;
    logic       received;
    logic [7:0] datareceive;
    logic       ack_err;
    logic       slave_low = 1'b0;

    int total = 0;
    int bad   = 0;

    logic scl_tr  [0:NTR];
    logic sda_tr  [0:NTR];
    logic busy_tr [0:NTR];
    logic snd_tr  [0:NTR];
    logic rcv_tr  [0:NTR];

    assign sda_i = ~(sda_oe | slave_low);

    always #5 clk = ~clk;

    i2c_byte_master #(.DIV(DIV)) dut (
        .clk(clk), .reset(reset), .start(start), .send(send), .datasend(datasend),
        .receive(receive), .last(last), .stop(stop), .sda_i(sda_i), .scl(scl),
        .sda_oe(sda_oe), .busy(busy), .sended(sended), .received(received),
        .datareceive(datareceive), .ack_err(ack_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle command; returns at the negedge just after the accepting posedge (k=1).
    task automatic issue(input logic s, input logic p, input logic w, input logic r,
                         input logic [7:0] d, input logic l);
        start = s; stop = p; send = w; receive = r; datasend = d; last = l;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; send = 1'b0; receive = 1'b0;
        datasend = 8'h00; last = 1'b0;
    endtask

    // mode 0: slave silent, 1: slave ACKs slot 8, 2: slave drives rbyte in slots 0..7
    task automatic capture(input int n, input int mode, input logic [7:0] rbyte);
        int slot;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) @(negedge clk);
            scl_tr[k] = scl; sda_tr[k] = sda_oe; busy_tr[k] = busy;
            snd_tr[k] = sended; rcv_tr[k] = received;
            slot = (k - 1) / SLOT;
            case (mode)
                1: slave_low = (slot == 8);
                2: slave_low = (slot < 8) ? ~rbyte[7 - slot] : 1'b0;
                default: slave_low = 1'b0;
            endcase
        end
        slave_low = 1'b0;
    endtask

    function automatic int count_busy(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (busy_tr[k]) c++;
        return c;
    endfunction

    function automatic int count_snd(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (snd_tr[k]) c++;
        return c;
    endfunction

    function automatic int count_rcv(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (rcv_tr[k]) c++;
        return c;
    endfunction

    // {scl,sda_oe} at the first cycle of q0..q3 of a four-phase primitive
    function automatic logic [7:0] phases();
        return {scl_tr[1], sda_tr[1], scl_tr[DIV+1], sda_tr[DIV+1],
                scl_tr[2*DIV+1], sda_tr[2*DIV+1], scl_tr[3*DIV+1], sda_tr[3*DIV+1]};
    endfunction

    function automatic logic [7:0] tx_byte();
        logic [7:0] b;
        for (int s = 0; s < 8; s++) b[7 - s] = ~sda_tr[s * SLOT + 2 * DIV + 1];
        return b;
    endfunction

    function automatic int scl_slots_ok();
        int c = 0;
        for (int s = 0; s < 9; s++)
            if (!scl_tr[s*SLOT+1] && scl_tr[s*SLOT+DIV+1] && scl_tr[s*SLOT+2*DIV+1] &&
                !scl_tr[s*SLOT+3*DIV+1]) c++;
        return c;
    endfunction

    function automatic int sda_driven(input int n);
        int c = 0;
        for (int k = 1; k <= n; k++) if (sda_tr[k]) c++;
        return c;
    endfunction

    initial begin
        // reset values
        repeat (3) @(negedge clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", 32'({sended, received}), 32'd0);
        check("rst_data", 32'(datareceive), 32'h00);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // commands other than start are ignored in IDLE
        issue(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0);
        capture(4, 0, 8'h00);
        check("idle_send_ignored", 32'(count_busy(4)), 32'd0);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        capture(4, 0, 8'h00);
        check("idle_recv_ignored", 32'(count_busy(4)), 32'd0);
        issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        capture(4, 0, 8'h00);
        check("idle_stop_ignored", 32'(count_busy(4) + sda_driven(4)), 32'd0);

        // START from IDLE
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        capture(4 * DIV + 1, 0, 8'h00);
        check("start_phases", 32'(phases()), 32'b10_10_11_01);
        check("start_busy_len", 32'(count_busy(4 * DIV)), 32'd16);
        check("start_busy_end", 32'(busy_tr[4 * DIV + 1]), 32'd0);
        check("start_no_pulse", 32'(count_snd(17) + count_rcv(17)), 32'd0);

        // send 0xEE, slave ACKs
        issue(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE, 1'b0);
        capture(36 * DIV + 1, 1, 8'h00);
        check("ee_bits", 32'(tx_byte()), 32'hEE);
        check("ee_scl_slots", 32'(scl_slots_ok()), 32'd9);
        check("ee_ack_released", 32'(sda_tr[8 * SLOT + 2 * DIV + 1]), 32'd0);
        check("ee_busy_len", 32'(count_busy(36 * DIV)), 32'd144);
        check("ee_sended_cnt", 32'(count_snd(145)), 32'd1);
        check("ee_sended_at", 32'(snd_tr[144]), 32'd1);
        check("ee_ack_err", 32'(ack_err), 32'd0);

        // send 0xF6, no slave
        issue(1'b0, 1'b0, 1'b1, 1'b0, 8'hF6, 1'b0);
        capture(36 * DIV + 1, 0, 8'h00);
        check("f6_bits", 32'(tx_byte()), 32'hF6);
        check("f6_sended_at", 32'(snd_tr[144] && count_snd(145) == 1), 32'd1);
        check("f6_ack_err", 32'(ack_err), 32'd1);

        // STOP: SDA rises while SCL high, then IDLE
        issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        capture(4 * DIV + 1, 0, 8'h00);
        check("stop_phases", 32'(phases()), 32'b01_11_10_10);
        check("stop_busy_len", 32'(count_busy(17)), 32'd16);
        check("stop_idle_bus", 32'({scl_tr[17], sda_tr[17]}), 32'b10);
        issue(1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 1'b0);
        capture(4, 0, 8'h00);
        check("post_stop_idle", 32'(count_busy(4)), 32'd0);
        check("ack_err_held", 32'(ack_err), 32'd1);

        // START, receive 0x55 with last=1
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        capture(4 * DIV + 1, 0, 8'h00);
        issue(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
        capture(36 * DIV + 1, 2, 8'h55);
        check("r55_data", 32'(datareceive), 32'h55);
        check("r55_master_released", 32'(sda_driven(36 * DIV)), 32'd0);
        check("r55_rcv_at", 32'(rcv_tr[144] && count_rcv(145) == 1), 32'd1);
        check("r55_no_sended", 32'(count_snd(145)), 32'd0);
        check("r55_busy_len", 32'(count_busy(145)), 32'd144);

        // repeated START
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        capture(4 * DIV + 1, 0, 8'h00);
        check("rstart_phases", 32'(phases()), 32'b00_10_11_01);

        // start and stop together in HOLD: START wins
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        capture(4 * DIV + 1, 0, 8'h00);
        check("pair_phases", 32'(phases()), 32'b00_10_11_01);
        check("pair_busy_len", 32'(count_busy(17)), 32'd16);

        // receive 0xA3 with last=0: master ACKs
        issue(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        capture(36 * DIV + 1, 2, 8'hA3);
        check("ra3_data", 32'(datareceive), 32'hA3);
        check("ra3_master_ack", 32'(sda_tr[8 * SLOT + 2 * DIV + 1]), 32'd1);

        // async reset in the middle of a send of 0x5A
        issue(1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0);
        capture(45, 0, 8'h00);
        check("mid_pre_state", 32'({scl, sda_oe, busy}), 32'b011);
        reset = 1'b0;
        #1;
        check("mid_rst_bus", 32'({scl, sda_oe}), 32'b10);
        check("mid_rst_outs", 32'({busy, sended, received, ack_err}), 32'd0);
        check("mid_rst_data", 32'(datareceive), 32'h00);
        @(negedge clk);
        reset = 1'b1;
        capture(150, 0, 8'h00);
        check("post_rst_quiet", 32'(count_busy(150) + count_snd(150) + count_rcv(150)), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_byte_master.md
# i2c_byte_master

Byte-level I2C master engine that executes the bus primitives requested by the BMP180 sensor controller. The controller issues start, send, receive and stop commands and waits for the completion pulses `sended` and `received`. This block replaces the push-button pulse generators currently standing in for a real bus. It generates SCL and open-drain SDA, serialises `datasend`, deserialises `datareceive`, and reports the slave ACK.

## Interface
- `DIV`, 125 — clk cycles per quarter SCL period (50 MHz → 100 kHz); legal range 2..65535
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle command: START, or repeated START if bus already owned
- `send`  in  1  one-cycle command: transmit `datasend`, then sample ACK
- `datasend`  in  8  byte to transmit, MSB first, captured on accepted `send`
- `receive`  in  1  one-cycle command: read one byte, then drive ACK/NACK
- `last`  in  1  captured with `receive`: 1 = master NACKs (final byte), 0 = master ACKs
- `stop`  in  1  one-cycle command: STOP condition, release bus
- `sda_i`  in  1  SDA pin level (already synchronised upstream)
- `scl`  out  1  SCL level (push-pull, 1 = high)
- `sda_oe`  out  1  1 = pull SDA low, 0 = release
- `busy`  out  1  command in progress; new commands ignored while high
- `sended`  out  1  one-cycle pulse: byte plus ACK slot complete
- `received`  out  1  one-cycle pulse: `datareceive` valid
- `datareceive`  out  8  last byte read, held until next receive completes
- `ack_err`  out  1  SDA level sampled in last ACK slot of a send (1 = NACK), held

## Operation
- States: IDLE (bus free), HOLD (bus owned, SCL low), START, WBIT, WACK, RBIT, RACK, STOP.
- Quarter counter counts DIV cycles per phase; phases q0..q3. Bit counter counts 7..0.
- Commands are accepted only when `busy`=0. If several arrive in one cycle, priority is start > stop > send > receive. Others are dropped.
- In IDLE, only `start` is accepted; `send`, `receive` and `stop` are ignored.
- In HOLD, all four commands are accepted. `start` produces a repeated START.
- START phases:
  - q0: SDA released, SCL unchanged.
  - q1: SCL high.
  - q2: SDA low (SCL high).
  - q3: SCL low.
  - Then HOLD.
- Data bit phases (WBIT/RBIT/ACK slots):
  - q0: SCL low, SDA set to the bit.
  - q1 and q2: SCL high.
  - q3: SCL low.
  - SDA is sampled on the first clk of q2.
- WBIT sends `datasend[7]` first. WACK releases SDA, samples it into `ack_err`, then pulses `sended` and returns to HOLD.
- RBIT releases SDA and shifts the samples in MSB first. RACK drives SDA low if `last`=0 and releases it if `last`=1. It then loads `datareceive`, pulses `received` and returns to HOLD.
- STOP phases:
  - q0: SCL low, SDA low.
  - q1: SCL high.
  - q2: SDA released.
  - q3: hold.
  - Then IDLE.
- No clock stretching or arbitration; `sda_i` is used only in sample slots.

## Timing
- Reset values: `scl`=1, `sda_oe`=0, `busy`=0, `sended`=0, `received`=0, `datareceive`=0x00, `ack_err`=0, state IDLE.
- Reset assertion mid-transfer releases the bus immediately, asynchronously, and aborts with no completion pulse.
- Accepted command at edge N: `busy`=1 from N+1, and q0 starts at N+1.
- Durations from acceptance to `busy` deassertion:
  - START: 4·DIV cycles.
  - STOP: 4·DIV cycles.
  - send: 36·DIV cycles.
  - receive: 36·DIV cycles.
- `sended` and `received` are high for exactly one cycle, coincident with the last cycle of `busy`=1.
- `datareceive` and `ack_err` update on that same edge.
- A command asserted in the cycle `busy` falls is ignored. The earliest acceptance is the following cycle.
- `datasend` and `last` need to be valid only in the acceptance cycle.

## Test plan
- DIV=4, `start` in IDLE → SDA falls while SCL is high, SCL falls at q3; `busy` high for 16 cycles; no `sended`/`received` pulse.
- After START, `send` with 0xEE and slave model ACKing → SCL edges and SDA bits show 1110_1110 MSB first; `ack_err`=0; `sended` pulses once 144 cycles after acceptance.
- `send` with 0xF6 and no slave (SDA floats high) → `ack_err`=1, `sended` still pulses; next `stop` gives SDA rising while SCL is high, then IDLE.
- `receive` with `last`=1 and slave driving 0x55 → `datareceive`=0x55, master leaves SDA released in RACK, `received` pulses once; then `start` produces a valid repeated START.
- `send`, `receive` and `stop` in IDLE, plus `start` and `stop` together in HOLD → IDLE commands ignored (`busy` stays 0); the simultaneous pair executes START only.
- `reset`=0 in the middle of a send → `scl`=1 and `sda_oe`=0 within the same cycle, all outputs at reset values, no pulses after `reset` returns high.
